// File: rtl/global_array_slot_ctrl_if.sv
// Mapper/scheduler-facing bus of the global array slot controller.
// The master side requests and releases slots; the slave side reports occupancy.
interface global_array_slot_ctrl_if #(
   parameter int IDX_W = 3,
   parameter int CNT_W = 4
);
   logic             alloc_valid;
   logic             alloc_type;
   logic             alloc_ready;
   logic [IDX_W-1:0] alloc_index;
   logic             free_valid;
   logic             free_type;
   logic [IDX_W-1:0] free_index;
   logic [CNT_W-1:0] read_count;
   logic [CNT_W-1:0] write_count;
   logic             read_full;
   logic             write_full;
   logic             read_empty;
   logic             write_empty;
   logic             err_double_free;

   modport master (
      output alloc_valid, alloc_type, free_valid, free_type, free_index,
      input  alloc_ready, alloc_index, read_count, write_count,
             read_full, write_full, read_empty, write_empty, err_double_free
   );

   modport slave (
      input  alloc_valid, alloc_type, free_valid, free_type, free_index,
      output alloc_ready, alloc_index, read_count, write_count,
             read_full, write_full, read_empty, write_empty, err_double_free
   );
endinterface

// File: rtl/global_array_slot_ctrl.sv
// Read/write slot allocator for the global request array: hands out the lowest
// free index per type, reclaims dispatched slots and flags illegal frees.
module global_array_slot_ctrl #(
   parameter int READ_ENTRIES  = 8,
   parameter int WRITE_ENTRIES = 8,
   parameter int IDX_W         = 3,
   parameter int CNT_W         = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   global_array_slot_ctrl_if.slave  bus
);

   logic [READ_ENTRIES-1:0]  read_busy_reg,  read_busy_next;
   logic [WRITE_ENTRIES-1:0] write_busy_reg, write_busy_next;
   logic [CNT_W-1:0]         read_count_reg, read_count_next;
   logic [CNT_W-1:0]         write_count_reg, write_count_next;
   logic                     err_reg, err_next;

   logic [IDX_W-1:0]         read_idx, write_idx;
   logic                     read_avail, write_avail;
   logic [READ_ENTRIES-1:0]  read_sel, read_set, read_clr;
   logic [WRITE_ENTRIES-1:0] write_sel, write_set, write_clr;
   logic                     read_alloc, write_alloc;
   logic                     read_free, write_free;

   // Lowest-index-first encoders; index stays 0 when every slot is taken.
   always_comb begin
      read_idx   = '0;
      read_avail = 1'b0;
      for (int i = READ_ENTRIES - 1; i >= 0; i--) begin
         if (!read_busy_reg[i]) begin
            read_avail = 1'b1;
            read_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      write_idx   = '0;
      write_avail = 1'b0;
      for (int i = WRITE_ENTRIES - 1; i >= 0; i--) begin
         if (!write_busy_reg[i]) begin
            write_avail = 1'b1;
            write_idx   = IDX_W'(i);
         end
      end
   end

   assign read_alloc  = bus.alloc_valid && !bus.alloc_type && read_avail;
   assign write_alloc = bus.alloc_valid &&  bus.alloc_type && write_avail;

   // An out-of-range free_index matches no select bit, so it reads as not busy.
   assign read_free  = bus.free_valid && !bus.free_type && |(read_busy_reg & read_sel);
   assign write_free = bus.free_valid &&  bus.free_type && |(write_busy_reg & write_sel);

   genvar gi;
   generate
      for (gi = 0; gi < READ_ENTRIES; gi++) begin : g_read
         assign read_sel[gi] = (bus.free_index == IDX_W'(gi));
         assign read_set[gi] = read_alloc && (read_idx == IDX_W'(gi));
         assign read_clr[gi] = read_free && read_sel[gi];
      end
      for (gi = 0; gi < WRITE_ENTRIES; gi++) begin : g_write
         assign write_sel[gi] = (bus.free_index == IDX_W'(gi));
         assign write_set[gi] = write_alloc && (write_idx == IDX_W'(gi));
         assign write_clr[gi] = write_free && write_sel[gi];
      end
   endgenerate

   always_comb begin
      read_busy_next  = (read_busy_reg  | read_set)  & ~read_clr;
      write_busy_next = (write_busy_reg | write_set) & ~write_clr;

      read_count_next = read_count_reg;
      if (read_alloc && !read_free)
         read_count_next = read_count_reg + CNT_W'(1);
      else if (!read_alloc && read_free)
         read_count_next = read_count_reg - CNT_W'(1);

      write_count_next = write_count_reg;
      if (write_alloc && !write_free)
         write_count_next = write_count_reg + CNT_W'(1);
      else if (!write_alloc && write_free)
         write_count_next = write_count_reg - CNT_W'(1);

      err_next = bus.free_valid && !(read_free || write_free);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read_busy_reg   <= '0;
         write_busy_reg  <= '0;
         read_count_reg  <= '0;
         write_count_reg <= '0;
         err_reg         <= 1'b0;
      end else begin
         read_busy_reg   <= read_busy_next;
         write_busy_reg  <= write_busy_next;
         read_count_reg  <= read_count_next;
         write_count_reg <= write_count_next;
         err_reg         <= err_next;
      end
   end

   assign bus.alloc_ready     = bus.alloc_type ? write_avail : read_avail;
   assign bus.alloc_index     = bus.alloc_type ? write_idx   : read_idx;
   assign bus.read_count      = read_count_reg;
   assign bus.write_count     = write_count_reg;
   assign bus.read_full       = (read_count_reg  == CNT_W'(READ_ENTRIES));
   assign bus.write_full      = (write_count_reg == CNT_W'(WRITE_ENTRIES));
   assign bus.read_empty      = (read_count_reg  == '0);
   assign bus.write_empty     = (write_count_reg == '0);
   assign bus.err_double_free = err_reg;

endmodule

// File: tb/tb_global_array_slot_ctrl.sv
// Self-checking bench for global_array_slot_ctrl: a bitmap reference model feeds
// a queue of expected alloc responses that is drained as the DUT answers.
module tb_global_array_slot_ctrl;

   localparam int IDX_W = 4;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   global_array_slot_ctrl_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

   global_array_slot_ctrl #(
      .READ_ENTRIES(8), .WRITE_ENTRIES(8), .IDX_W(IDX_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] rb, wb;
   logic       err_exp;
   logic [4:0] exp_q[$];
   logic [3:0] got_idx;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] lowest_free(input logic [7:0] bm);
      lowest_free = 4'd0;
      for (int i = 7; i >= 0; i--)
         if (!bm[i]) lowest_free = 4'(i);
   endfunction

   task automatic check_state(input string tag);
      check_val({tag, ".read_count"},  32'(bus.read_count),  32'($countones(rb)));
      check_val({tag, ".write_count"}, 32'(bus.write_count), 32'($countones(wb)));
      check_val({tag, ".read_full"},   32'(bus.read_full),   32'(rb == 8'hFF));
      check_val({tag, ".write_full"},  32'(bus.write_full),  32'(wb == 8'hFF));
      check_val({tag, ".read_empty"},  32'(bus.read_empty),  32'(rb == 8'h00));
      check_val({tag, ".write_empty"}, 32'(bus.write_empty), 32'(wb == 8'h00));
      check_val({tag, ".err"},         32'(bus.err_double_free), 32'(err_exp));
   endtask

   // One cycle: drive at negedge, compare alloc response, clock, compare state.
   task automatic step(input string tag, input logic av, input logic at,
                       input logic fv, input logic ft, input logic [3:0] fi,
                       output logic [3:0] idx);
      logic [7:0] bm;
      logic [4:0] e;
      logic       acc, legal;
      @(negedge clk);
      bus.alloc_valid = av;
      bus.alloc_type  = at;
      bus.free_valid  = fv;
      bus.free_type   = ft;
      bus.free_index  = fi;
      bm = at ? wb : rb;
      exp_q.push_back({bm != 8'hFF, (bm != 8'hFF) ? lowest_free(bm) : 4'd0});
      #1;
      e = exp_q.pop_front();
      check_val({tag, ".alloc_ready"}, 32'(bus.alloc_ready), 32'(e[4]));
      check_val({tag, ".alloc_index"}, 32'(bus.alloc_index), 32'(e[3:0]));
      idx = bus.alloc_index;
      acc = av && e[4];
      legal = fv && (fi < 4'd8) && (ft ? wb[fi[2:0]] : rb[fi[2:0]]);
      @(posedge clk);
      if (acc) begin
         if (at) wb[e[2:0]] = 1'b1;
         else    rb[e[2:0]] = 1'b1;
      end
      if (legal) begin
         if (ft) wb[fi[2:0]] = 1'b0;
         else    rb[fi[2:0]] = 1'b0;
      end
      err_exp = fv && !legal;
      #1;
      check_state(tag);
      $display("txn %s av=%0b at=%0b fv=%0b ft=%0b fi=%0d idx=%0d rc=%0d wc=%0d err=%0b",
               tag, av, at, fv, ft, fi, idx, bus.read_count, bus.write_count, bus.err_double_free);
   endtask

   task automatic model_reset();
      rb = '0;
      wb = '0;
      err_exp = 1'b0;
   endtask

   initial begin
      bus.alloc_valid = 1'b0;
      bus.alloc_type  = 1'b0;
      bus.free_valid  = 1'b0;
      bus.free_type   = 1'b0;
      bus.free_index  = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_state("reset");
      check_val("reset.alloc_ready", 32'(bus.alloc_ready), 32'd1);
      check_val("reset.alloc_index", 32'(bus.alloc_index), 32'd0);

      for (int i = 0; i < 8; i++) begin
         step("fill_rd", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, got_idx);
         check_val("fill_rd.idx", 32'(got_idx), 32'(i));
      end
      check_val("fill_rd.full", 32'(bus.read_full), 32'd1);
      check_val("fill_rd.count", 32'(bus.read_count), 32'd8);
      step("rd_blocked", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, got_idx);
      step("wr_ready", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, got_idx);
      check_val("wr_ready.idx", 32'(got_idx), 32'd0);

      step("free5", 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, got_idx);
      step("free2", 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, got_idx);
      check_val("holes.count", 32'(bus.read_count), 32'd6);
      step("hole_a", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, got_idx);
      check_val("hole_a.idx", 32'(got_idx), 32'd2);
      step("hole_b", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, got_idx);
      check_val("hole_b.idx", 32'(got_idx), 32'd5);
      check_val("holes.full", 32'(bus.read_full), 32'd1);

      for (int i = 0; i < 8; i++)
         step("fill_wr", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, got_idx);
      step("simul_full", 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, got_idx);
      check_val("simul_full.count", 32'(bus.write_count), 32'd7);
      step("simul_next", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, got_idx);
      check_val("simul_next.idx", 32'(got_idx), 32'd3);

      step("free_w4", 1'b0, 1'b1, 1'b1, 1'b1, 4'd4, got_idx);
      step("dbl_w4", 1'b0, 1'b1, 1'b1, 1'b1, 4'd4, got_idx);
      check_val("dbl_w4.err", 32'(bus.err_double_free), 32'd1);
      check_val("dbl_w4.count", 32'(bus.write_count), 32'd7);
      step("dbl_idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, got_idx);
      check_val("dbl_idle.err", 32'(bus.err_double_free), 32'd0);
      step("oor_r9", 1'b0, 1'b0, 1'b1, 1'b0, 4'd9, got_idx);
      check_val("oor_r9.err", 32'(bus.err_double_free), 32'd1);
      check_val("oor_r9.count", 32'(bus.read_count), 32'd8);

      // Mid-cycle asynchronous reset after three write allocations.
      @(negedge clk);
      rst = 1'b1;
      #1;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++)
         step("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, got_idx);
      @(negedge clk);
      bus.alloc_valid = 1'b0;
      bus.free_valid  = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_val("async.write_count", 32'(bus.write_count), 32'd0);
      check_val("async.write_empty", 32'(bus.write_empty), 32'd1);
      rst = 1'b0;
      model_reset();
      step("post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, got_idx);
      check_val("post_rst.idx", 32'(got_idx), 32'd0);

      for (int n = 0; n < 300; n++)
         step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 9)), got_idx);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
